wt_mem_responder: RTL and testbench
===================================

# wt_mem_responder

Memory-side responder for the write-through cache subsystem's adapter-level request interface. It accepts I$ fill requests and D$ load and store requests, arbitrates between the two ports, and services them from a local byte-writable memory. After a programmable latency it returns response packets. It serves as a tightly-coupled memory and as the closed-loop partner of the cache subsystem in block-level benches, with no AXI or L1.5 adapter involved.

## Interface
- `MemWords`, 1024: number of 64-bit words of backing memory; must be a power of two.
- `Latency`, 2: cycles from request acceptance to response; must be ≥1.
- `AddrWidth`, 56: physical address width.
- `clk_i` in 1: the block's only clock.
- `rst_ni` in 1: synchronous, active-low reset.
- `icache_data_req_i` in 1: I$ fill request valid.
- `icache_data_ack_o` out 1: I$ request accepted this cycle.
- `icache_paddr_i` in AddrWidth: fill address.
- `icache_tid_i` in 2: transaction ID.
- `icache_rtrn_vld_o` out 1: I$ response valid, one-cycle pulse.
- `icache_rtrn_data_o` out 128: aligned 16-byte line.
- `icache_rtrn_tid_o` out 2: echoed transaction ID.
- `dcache_data_req_i` in 1: D$ request valid.
- `dcache_data_ack_o` out 1: D$ request accepted this cycle.
- `dcache_rtype_i` in 1: request type, 0 = load, 1 = store.
- `dcache_paddr_i` in AddrWidth: request address.
- `dcache_size_i` in 3: access size, 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B; other values are treated as 3.
- `dcache_wdata_i` in 64: store data, byte-lane aligned.
- `dcache_tid_i` in 2: transaction ID.
- `dcache_rtrn_vld_o` out 1: D$ response valid, one-cycle pulse.
- `dcache_rtrn_type_o` out 1: response type, 0 = load data, 1 = store ack.
- `dcache_rtrn_data_o` out 128: load line; all zeros for a store ack.
- `dcache_rtrn_tid_o` out 2: echoed transaction ID.

## Operation
- There is one transaction in flight at a time. The FSM has three states: IDLE, WAIT, RESP.
- In IDLE, any request is granted:
  - The grant drives the matching `*_data_ack_o` high combinationally in the same cycle.
  - The request fields are captured into registers.
  - Next state is RESP if `Latency` == 1, otherwise WAIT with the counter loaded with `Latency`-2.
- WAIT decrements the counter and moves to RESP when the counter is 0.
- RESP pulses the rtrn_vld of the granted port for one cycle, then returns to IDLE.
- Acks are never high outside IDLE. Requesters hold req and fields until they see ack.
- Arbitration is round-robin:
  - The priority pointer resets to I$.
  - After any grant the pointer moves to the other port.
  - When both ports request in IDLE, the port under the pointer wins. The loser stays pending, unacked.
- Memory indexing:
  - Word index = `paddr[3+log2(MemWords)-1:3]`. Upper address bits are ignored, so addresses wrap modulo memory size.
  - A line is the two words at `{index[hi:1],0}` and `{index[hi:1],1}`. The lower word goes in `data[63:0]`.
- Loads and I$ fills return the full aligned 16-byte line containing the address, whatever the size.
- Stores:
  - The byte enable is derived from `paddr[2:0]` and size. Bytes that would fall beyond bit 63 are dropped; there is no wrap into the next word.
  - The store is written at the rising edge that ends the RESP cycle, so a load accepted afterwards observes it.
  - Store ack data is zero.
- Reset clears the FSM, counter, pointer and all rtrn outputs to 0. Memory contents are not reset.
- Reset asserted mid-transaction drops the transaction: no response is issued, and a pending store is not written.

## Timing
- An acceptance at cycle t produces rtrn_vld at cycle t+`Latency`. The next acceptance can happen at t+`Latency`+1 at the earliest.
- Throughput is one transaction per `Latency`+1 cycles.
- The rtrn data, type and tid outputs are registered. They are zero after reset and hold their last value while vld is low.
- Ack has a combinational path from `*_data_req_i` and the state. There is no combinational path from inputs to any rtrn output.

## Structure
- Shared package `wt_cache_pkg` gets the following additions:
  - an `mem_rtype_t` enum: LOAD, STORE.
  - a function `size_to_be(size, offset)` that returns an 8-bit byte enable.
  - a constant `MEM_LINE_WIDTH` = 128.
- One sub-module, `wt_resp_sram`: a single-port, 64-bit-wide, byte-enabled array with line read of two words. Reads are asynchronous and internal to this block; writes are synchronous with byte enable.

## Test plan
- Reset, then idle for 10 cycles -> all acks and vld stay 0; all rtrn data stays 0.
- D$ store at paddr 0x10, size 3, data 0x1122334455667788, tid 1, Latency 2 -> ack at t; `dcache_rtrn_vld_o` at t+2 with type 1, tid 1, data 0. A following load of 0x10 returns line bits[63:0] = 0x1122334455667788.
- Store at paddr 0x16, size 2, data 0xAABBCCDD_00000000 over a word of zeros -> only bytes 6 and 7 are written. The load returns 0xAABB000000000000 in the low word; the upper word is unchanged.
- I$ and D$ request in the same cycle after reset -> I$ is acked first; D$ is acked at t+`Latency`+1. With both requesting again, D$ wins next.
- With MemWords = 1024, a store to paddr 0x2000+0x8 -> a load from 0x8 returns the stored data (wrap-around).
- Reset asserted during WAIT of a store -> no rtrn_vld; a load of that address after reset returns the old data.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared write-through cache subsystem types and helpers.
// Holds the memory-responder request type, line width and byte-enable helper.
package wt_cache_pkg;

    localparam int unsigned MEM_LINE_WIDTH = 128;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } mem_rtype_t;

    // Sizes above 3 behave as 8 bytes; lanes shifted past byte 7 are dropped.
    function automatic logic [7:0] size_to_be(input logic [2:0] size, input logic [2:0] offset);
        logic [15:0] mask;
        logic [15:0] shifted;
        case (size)
            3'd0:    mask = 16'h0001;
            3'd1:    mask = 16'h0003;
            3'd2:    mask = 16'h000F;
            default: mask = 16'h00FF;
        endcase
        shifted = mask << offset;
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/wt_resp_sram.sv
// Single-port 64-bit byte-writable backing array for wt_mem_responder.
// Reads return the aligned two-word line asynchronously; writes are synchronous.
module wt_resp_sram
    import wt_cache_pkg::*;
#(
    parameter int unsigned MemWords = 1024,
    localparam int unsigned IdxW = $clog2(MemWords)
) (
    input  logic                      clk_i,
    input  logic [IdxW-1:0]           rd_idx_i,
    output logic [MEM_LINE_WIDTH-1:0] rd_line_o,
    input  logic                      we_i,
    input  logic [IdxW-1:0]           wr_idx_i,
    input  logic [7:0]                be_i,
    input  logic [63:0]               wdata_i
);

    logic [63:0] mem [MemWords];
    logic [IdxW-1:0] idx_lo;
    logic [IdxW-1:0] idx_hi;

    assign idx_lo    = {rd_idx_i[IdxW-1:1], 1'b0};
    assign idx_hi    = {rd_idx_i[IdxW-1:1], 1'b1};
    assign rd_line_o = {mem[idx_hi], mem[idx_lo]};

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (be_i[b]) begin
                    mem[wr_idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/wt_mem_responder.sv
// Memory-side responder for the write-through cache adapter interface:
// round-robin I$/D$ arbitration, one transaction in flight, fixed-latency responses.
module wt_mem_responder
    import wt_cache_pkg::*;
#(
    parameter int unsigned MemWords  = 1024,
    parameter int unsigned Latency   = 2,
    parameter int unsigned AddrWidth = 56
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      icache_data_req_i,
    output logic                      icache_data_ack_o,
    input  logic [AddrWidth-1:0]      icache_paddr_i,
    input  logic [1:0]                icache_tid_i,
    output logic                      icache_rtrn_vld_o,
    output logic [MEM_LINE_WIDTH-1:0] icache_rtrn_data_o,
    output logic [1:0]                icache_rtrn_tid_o,
    input  logic                      dcache_data_req_i,
    output logic                      dcache_data_ack_o,
    input  logic                      dcache_rtype_i,
    input  logic [AddrWidth-1:0]      dcache_paddr_i,
    input  logic [2:0]                dcache_size_i,
    input  logic [63:0]               dcache_wdata_i,
    input  logic [1:0]                dcache_tid_i,
    output logic                      dcache_rtrn_vld_o,
    output logic                      dcache_rtrn_type_o,
    output logic [MEM_LINE_WIDTH-1:0] dcache_rtrn_data_o,
    output logic [1:0]                dcache_rtrn_tid_o
);

    localparam int unsigned IdxW = $clog2(MemWords);
    localparam int unsigned CntW = $clog2(Latency + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    typedef enum logic {PORT_I, PORT_D} port_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    port_e           ptr_q, ptr_d;

    port_e           port_q;
    mem_rtype_t      rtype_q;
    logic [1:0]      tid_q;
    logic [IdxW-1:0] idx_q;
    logic [7:0]      be_q;
    logic [63:0]     wdata_q;

    logic            grant_i, grant_d;
    port_e           cur_port;
    mem_rtype_t      cur_rtype;
    logic [1:0]      cur_tid;
    logic [IdxW-1:0] cur_idx;
    logic [MEM_LINE_WIDTH-1:0] line;
    logic            mem_we;

    // cur_* selects the live request while granting in IDLE, so Latency == 1
    // can read the line and fill the response registers in the grant cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        cur_port  = port_q;
        cur_rtype = rtype_q;
        cur_tid   = tid_q;
        cur_idx   = idx_q;
        unique case (state_q)
            IDLE: begin
                grant_i = icache_data_req_i && (!dcache_data_req_i || ptr_q == PORT_I);
                grant_d = dcache_data_req_i && !grant_i;
                if (grant_i) begin
                    cur_port  = PORT_I;
                    cur_rtype = LOAD;
                    cur_tid   = icache_tid_i;
                    cur_idx   = icache_paddr_i[3 +: IdxW];
                end else if (grant_d) begin
                    cur_port  = PORT_D;
                    cur_rtype = mem_rtype_t'(dcache_rtype_i);
                    cur_tid   = dcache_tid_i;
                    cur_idx   = dcache_paddr_i[3 +: IdxW];
                end
                if (grant_i || grant_d) begin
                    ptr_d = grant_i ? PORT_D : PORT_I;
                    if (Latency == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CntW'(Latency - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign icache_data_ack_o = grant_i;
    assign dcache_data_ack_o = grant_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= PORT_I;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && (grant_i || grant_d)) begin
            port_q  <= cur_port;
            rtype_q <= cur_rtype;
            tid_q   <= cur_tid;
            idx_q   <= cur_idx;
            be_q    <= size_to_be(dcache_size_i, dcache_paddr_i[2:0]);
            wdata_q <= dcache_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            icache_rtrn_vld_o  <= 1'b0;
            icache_rtrn_data_o <= '0;
            icache_rtrn_tid_o  <= '0;
            dcache_rtrn_vld_o  <= 1'b0;
            dcache_rtrn_type_o <= 1'b0;
            dcache_rtrn_data_o <= '0;
            dcache_rtrn_tid_o  <= '0;
        end else begin
            icache_rtrn_vld_o <= 1'b0;
            dcache_rtrn_vld_o <= 1'b0;
            if (state_d == RESP) begin
                if (cur_port == PORT_I) begin
                    icache_rtrn_vld_o  <= 1'b1;
                    icache_rtrn_data_o <= line;
                    icache_rtrn_tid_o  <= cur_tid;
                end else begin
                    dcache_rtrn_vld_o  <= 1'b1;
                    dcache_rtrn_type_o <= (cur_rtype == STORE);
                    dcache_rtrn_data_o <= (cur_rtype == STORE) ? '0 : line;
                    dcache_rtrn_tid_o  <= cur_tid;
                end
            end
        end
    end

    // Store commits on the edge closing RESP; a reset on that edge cancels it.
    assign mem_we = rst_ni && state_q == RESP && port_q == PORT_D && rtype_q == STORE;

    wt_resp_sram #(
        .MemWords(MemWords)
    ) u_sram (
        .clk_i    (clk_i),
        .rd_idx_i (cur_idx),
        .rd_line_o(line),
        .we_i     (mem_we),
        .wr_idx_i (idx_q),
        .be_i     (be_q),
        .wdata_i  (wdata_q)
    );

endmodule

// File: tb/tb_wt_mem_responder.sv
// Directed bench for wt_mem_responder: table of D$ transactions plus
// hand-written arbitration and reset-abort sequences.
module tb_wt_mem_responder;
    import wt_cache_pkg::*;

    localparam int unsigned Latency = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         icache_data_req = 1'b0;
    logic         icache_data_ack_o;
    logic [55:0]  icache_paddr = '0;
    logic [1:0]   icache_tid = '0;
    logic         icache_rtrn_vld_o;
    logic [127:0] icache_rtrn_data_o;
    logic [1:0]   icache_rtrn_tid_o;
    logic         dcache_data_req = 1'b0;
    logic         dcache_data_ack_o;
    logic         dcache_rtype = 1'b0;
    logic [55:0]  dcache_paddr = '0;
    logic [2:0]   dcache_size = '0;
    logic [63:0]  dcache_wdata = '0;
    logic [1:0]   dcache_tid = '0;
    logic         dcache_rtrn_vld_o;
    logic         dcache_rtrn_type_o;
    logic [127:0] dcache_rtrn_data_o;
    logic [1:0]   dcache_rtrn_tid_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    wt_mem_responder #(
        .MemWords (1024),
        .Latency  (Latency),
        .AddrWidth(56)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .icache_data_req_i (icache_data_req),
        .icache_data_ack_o (icache_data_ack_o),
        .icache_paddr_i    (icache_paddr),
        .icache_tid_i      (icache_tid),
        .icache_rtrn_vld_o (icache_rtrn_vld_o),
        .icache_rtrn_data_o(icache_rtrn_data_o),
        .icache_rtrn_tid_o (icache_rtrn_tid_o),
        .dcache_data_req_i (dcache_data_req),
        .dcache_data_ack_o (dcache_data_ack_o),
        .dcache_rtype_i    (dcache_rtype),
        .dcache_paddr_i    (dcache_paddr),
        .dcache_size_i     (dcache_size),
        .dcache_wdata_i    (dcache_wdata),
        .dcache_tid_i      (dcache_tid),
        .dcache_rtrn_vld_o (dcache_rtrn_vld_o),
        .dcache_rtrn_type_o(dcache_rtrn_type_o),
        .dcache_rtrn_data_o(dcache_rtrn_data_o),
        .dcache_rtrn_tid_o (dcache_rtrn_tid_o)
    );

    typedef struct {
        logic         rtype;
        logic [55:0]  paddr;
        logic [2:0]   size;
        logic [63:0]  wdata;
        logic [1:0]   tid;
        logic [127:0] exp_data;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered at posedge+1; returns at posedge+1 after the response pulse.
    task automatic d_txn(input vec_t v, input string tag);
        int unsigned wait_cnt;
        int unsigned lat;
        dcache_data_req = 1'b1;
        dcache_rtype    = v.rtype;
        dcache_paddr    = v.paddr;
        dcache_size     = v.size;
        dcache_wdata    = v.wdata;
        dcache_tid      = v.tid;
        wait_cnt = 0;
        @(negedge clk);
        while (!dcache_data_ack_o && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check({tag, "_ack"}, 128'(dcache_data_ack_o), 128'd1);
        @(posedge clk); #1;
        dcache_data_req = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!dcache_rtrn_vld_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(Latency));
        check({tag, "_type"}, 128'(dcache_rtrn_type_o), 128'(v.rtype));
        check({tag, "_tid"}, 128'(dcache_rtrn_tid_o), 128'(v.tid));
        check({tag, "_data"}, dcache_rtrn_data_o, v.exp_data);
        check({tag, "_ivld"}, 128'(icache_rtrn_vld_o), 128'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 128'(dcache_rtrn_vld_o), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 56'h10,   3'd3, 64'h1122334455667788, 2'd1, 128'h0};
        vecs[1]  = '{1'b1, 56'h18,   3'd3, 64'h0000000000000000, 2'd2, 128'h0};
        vecs[2]  = '{1'b0, 56'h10,   3'd0, 64'h0,                2'd3, {64'h0000000000000000, 64'h1122334455667788}};
        vecs[3]  = '{1'b1, 56'h10,   3'd3, 64'h0000000000000000, 2'd0, 128'h0};
        vecs[4]  = '{1'b1, 56'h18,   3'd3, 64'hDEADBEEFCAFEF00D, 2'd1, 128'h0};
        vecs[5]  = '{1'b1, 56'h16,   3'd2, 64'hAABBCCDD00000000, 2'd2, 128'h0};
        vecs[6]  = '{1'b0, 56'h18,   3'd1, 64'h0,                2'd3, {64'hDEADBEEFCAFEF00D, 64'hAABB000000000000}};
        vecs[7]  = '{1'b1, 56'h1A,   3'd1, 64'h00000000BEEF0000, 2'd0, 128'h0};
        vecs[8]  = '{1'b0, 56'h10,   3'd3, 64'h0,                2'd1, {64'hDEADBEEFBEEFF00D, 64'hAABB000000000000}};
        vecs[9]  = '{1'b1, 56'h2008, 3'd3, 64'h0123456789ABCDEF, 2'd3, 128'h0};
        vecs[10] = '{1'b1, 56'h0,    3'd3, 64'h0000000000000055, 2'd0, 128'h0};
        vecs[11] = '{1'b0, 56'h8,    3'd2, 64'h0,                2'd1, {64'h0123456789ABCDEF, 64'h0000000000000055}};
        vecs[12] = '{1'b1, 56'h3,    3'd0, 64'h00000000AA000000, 2'd2, 128'h0};
        vecs[13] = '{1'b1, 56'hD,    3'd3, 64'h1111111111111111, 2'd3, 128'h0};
        vecs[14] = '{1'b0, 56'h2000, 3'd3, 64'h0,                2'd0, {64'h1111116789ABCDEF, 64'h00000000AA000055}};
        vecs[15] = '{1'b1, 56'h18,   3'd5, 64'h7777777777777777, 2'd1, 128'h0};
        vecs[16] = '{1'b0, 56'h1F,   3'd0, 64'h0,                2'd2, {64'h7777777777777777, 64'hAABB000000000000}};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ctrl", {icache_data_ack_o, dcache_data_ack_o, icache_rtrn_vld_o,
                                dcache_rtrn_vld_o, dcache_rtrn_type_o, icache_rtrn_tid_o,
                                dcache_rtrn_tid_o}, 128'd0);
            check("idle_idata", icache_rtrn_data_o, 128'd0);
            check("idle_ddata", dcache_rtrn_data_o, 128'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            d_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Simultaneous requests after reset: I$ first, D$ next, then I$ again.
        do_reset();
        icache_data_req = 1'b1;
        icache_paddr    = 56'h8;
        icache_tid      = 2'd1;
        dcache_data_req = 1'b1;
        dcache_rtype    = 1'b0;
        dcache_paddr    = 56'h18;
        dcache_size     = 3'd3;
        dcache_tid      = 2'd2;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("arb_iack_k%0d", k), 128'(icache_data_ack_o), 128'(k == 0 || k == 6));
            check($sformatf("arb_dack_k%0d", k), 128'(dcache_data_ack_o), 128'(k == 3));
            check($sformatf("arb_ivld_k%0d", k), 128'(icache_rtrn_vld_o), 128'(k == 2 || k == 8));
            check($sformatf("arb_dvld_k%0d", k), 128'(dcache_rtrn_vld_o), 128'(k == 5));
            if (k == 2) begin
                check("arb_i1_data", icache_rtrn_data_o, {64'h1111116789ABCDEF, 64'h00000000AA000055});
                check("arb_i1_tid", 128'(icache_rtrn_tid_o), 128'd1);
            end
            if (k == 5) begin
                check("arb_d_data", dcache_rtrn_data_o, {64'h7777777777777777, 64'hAABB000000000000});
                check("arb_d_tid", 128'(dcache_rtrn_tid_o), 128'd2);
            end
            if (k == 8) begin
                check("arb_i2_data", icache_rtrn_data_o, {64'h1111116789ABCDEF, 64'h00000000AA000055});
                check("arb_i2_tid", 128'(icache_rtrn_tid_o), 128'd3);
            end
            @(posedge clk); #1;
            if (k == 0) begin
                icache_paddr = 56'h2000;
                icache_tid   = 2'd3;
            end
            if (k == 3) dcache_data_req = 1'b0;
            if (k == 6) icache_data_req = 1'b0;
        end

        // Reset during WAIT of a store: no response and no write.
        dcache_data_req = 1'b1;
        dcache_rtype    = 1'b1;
        dcache_paddr    = 56'h10;
        dcache_size     = 3'd3;
        dcache_wdata    = 64'h9999999999999999;
        dcache_tid      = 2'd1;
        @(negedge clk);
        check("abort_ack", 128'(dcache_data_ack_o), 128'd1);
        @(posedge clk); #1;
        dcache_data_req = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort_rst_vld_k%0d", k), 128'(dcache_rtrn_vld_o), 128'd0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("abort_post_vld_k%0d", k), 128'(dcache_rtrn_vld_o), 128'd0);
            check($sformatf("abort_post_data_k%0d", k), dcache_rtrn_data_o, 128'd0);
            @(posedge clk); #1;
        end
        d_txn('{1'b0, 56'h10, 3'd3, 64'h0, 2'd3, {64'h7777777777777777, 64'hAABB000000000000}},
              "abort_load");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
